// File: rtl/ramb_dp_param.sv
// ============================================================================
// Module   : ramb_dp_param
// Purpose  : Parametrised true-dual-port synchronous block RAM with a single
//            shared clock. Each port has byte-lane write enables, a selectable
//            same-port read-during-write mode, a synchronous output clear and
//            a valid flag. There is an optional second output register stage.
//            An optional clear sweep zeroes the whole array after reset, and
//            BUSY is raised while the sweep runs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DW      data width per port (multiple of BW)
//   AW      address width, depth = 2**AW words
//   BW      byte-lane width, DW/BW write-enable bits per port
//   MODE_A  port A read-during-write: 0 write-first, 1 read-first, 2 no-change
//   MODE_B  port B read-during-write, same encoding as MODE_A
//   OREG    1 = extra output register on both ports (read latency 2)
//   CLR_RST 1 = zero the whole array after reset
// Ports
//   CLKA              in   clock for both ports, rising edge
//   RSTB              in   synchronous active-high reset
//   ENA / ENB         in   port enable
//   WEA / WEB         in   byte-lane write enables
//   ADDRA / ADDRB     in   word address
//   DIA / DIB         in   write data
//   SRA / SRB         in   output sync clear, effective only with port enable
//   DOA / DOB         out  read data
//   VLDA / VLDB       out  read data valid
//   BUSY              out  clear sweep in progress, port requests ignored
// ============================================================================
`default_nettype none

module ramb_dp_param #(
    parameter int DW      = 16,
    parameter int AW      = 9,
    parameter int BW      = 8,
    parameter int MODE_A  = 0,
    parameter int MODE_B  = 0,
    parameter int OREG    = 0,
    parameter int CLR_RST = 1
) (
    input  logic                 CLKA,
    input  logic                 RSTB,
    // port A
    input  logic                 ENA,
    input  logic [DW/BW-1:0]     WEA,
    input  logic [AW-1:0]        ADDRA,
    input  logic [DW-1:0]        DIA,
    input  logic                 SRA,
    output logic [DW-1:0]        DOA,
    output logic                 VLDA,
    // port B
    input  logic                 ENB,
    input  logic [DW/BW-1:0]     WEB,
    input  logic [AW-1:0]        ADDRB,
    input  logic [DW-1:0]        DIB,
    input  logic                 SRB,
    output logic [DW-1:0]        DOB,
    output logic                 VLDB,
    // status
    output logic                 BUSY
);

    localparam int          c_nb    = DW / BW;
    localparam int          c_depth = 2 ** AW;
    // Counter value of the last word written by the sweep.
    localparam logic [AW:0] c_last  = {1'b0, {AW{1'b1}}};

    // ------------------------------------------------------------------------
    // Control FSM: clear sweep after reset, then ready forever.
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_READY = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW:0]     r_cnt;
    logic            r_busy;

    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            r_state <= (CLR_RST != 0) ? S_CLEAR : S_READY;
            r_cnt   <= '0;
            r_busy  <= (CLR_RST != 0);
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = r_busy;

    // Reset takes priority over both the sweep and port traffic.
    logic w_clr;
    logic w_act;

    assign w_clr = (r_state == S_CLEAR) && !RSTB;
    assign w_act = (r_state == S_READY) && !RSTB;

    // ------------------------------------------------------------------------
    // Storage array. Port B lanes are assigned before port A lanes so that
    // on a same-address, same-lane collision the later assignment (port A)
    // is the one that lands.
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_mem [c_depth];

    always_ff @(posedge CLKA) begin
        if (w_clr) begin
            r_mem[r_cnt[AW-1:0]] <= '0;
        end else if (w_act) begin
            for (int l = 0; l < c_nb; l++) begin
                if (ENB && WEB[l]) begin
                    r_mem[ADDRB][l*BW +: BW] <= DIB[l*BW +: BW];
                end
                if (ENA && WEA[l]) begin
                    r_mem[ADDRA][l*BW +: BW] <= DIA[l*BW +: BW];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-port read path. Index 0 is port A, index 1 is port B.
    // ------------------------------------------------------------------------
    logic [1:0]                  w_en;
    logic [1:0]                  w_sr;
    logic [1:0][c_nb-1:0]        w_we;
    logic [1:0][AW-1:0]          w_addr;
    logic [1:0][DW-1:0]          w_di;
    logic [1:0][DW-1:0]          w_do;
    logic [1:0]                  w_vld;

    assign w_en   = {ENB, ENA};
    assign w_sr   = {SRB, SRA};
    assign w_we   = {WEB, WEA};
    assign w_addr = {ADDRB, ADDRA};
    assign w_di   = {DIB, DIA};

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int c_mode = (p == 0) ? MODE_A : MODE_B;

        logic [DW-1:0] w_old;
        logic [DW-1:0] w_mrg;
        logic [DW-1:0] r_d1;
        logic          r_v1;

        // Array contents before this edge's writes; the other port's write
        // in the same cycle is therefore never visible here.
        assign w_old = r_mem[w_addr[p]];

        // Word as it will look after this port's own lane writes.
        always_comb begin
            w_mrg = w_old;
            for (int l = 0; l < c_nb; l++) begin
                if (w_we[p][l]) begin
                    w_mrg[l*BW +: BW] = w_di[p][l*BW +: BW];
                end
            end
        end

        always_ff @(posedge CLKA) begin
            if (RSTB) begin
                r_d1 <= '0;
                r_v1 <= 1'b0;
            end else if (!w_act || !w_en[p]) begin
                r_v1 <= 1'b0;
            end else if (w_sr[p]) begin
                r_d1 <= '0;
                r_v1 <= 1'b1;
            end else if (w_we[p] == '0) begin
                r_d1 <= w_old;
                r_v1 <= 1'b1;
            end else if (c_mode == 0) begin
                r_d1 <= w_mrg;
                r_v1 <= 1'b1;
            end else if (c_mode == 1) begin
                r_d1 <= w_old;
                r_v1 <= 1'b1;
            end else begin
                // no-change: output keeps the previous read
                r_v1 <= 1'b0;
            end
        end

        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] r_d2;
            logic          r_v2;

            always_ff @(posedge CLKA) begin
                if (RSTB) begin
                    r_d2 <= '0;
                    r_v2 <= 1'b0;
                end else begin
                    r_d2 <= r_d1;
                    r_v2 <= r_v1;
                end
            end

            assign w_do[p]  = r_d2;
            assign w_vld[p] = r_v2;
        end else begin : g_noreg
            assign w_do[p]  = r_d1;
            assign w_vld[p] = r_v1;
        end
    end

    assign DOA  = w_do[0];
    assign VLDA = w_vld[0];
    assign DOB  = w_do[1];
    assign VLDB = w_vld[1];

endmodule

`default_nettype wire

// File: tb/tb_ramb_dp_param.sv
// ============================================================================
// Module   : tb_ramb_dp_param
// Purpose  : Self-checking bench for ramb_dp_param. Three instances
//            (DW=16, AW=4, BW=8) share one stimulus stream and cover every
//            read-during-write mode on each port, with and without the
//            output register. A word-level reference model predicts every
//            output after every clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ramb_dp_param;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena, enb, sra, srb;
    logic [1:0]  wea, web;
    logic [3:0]  addra, addrb;
    logic [15:0] dia, dib;

    logic [2:0][15:0] doa, dob;
    logic [2:0]       vlda, vldb, busy;

    always #5 clk = ~clk;

    ramb_dp_param #(.DW(16), .AW(4), .BW(8), .MODE_A(0), .MODE_B(1), .OREG(0), .CLR_RST(1)) u0 (
        .CLKA(clk), .RSTB(rstb),
        .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .SRA(sra), .DOA(doa[0]), .VLDA(vlda[0]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .SRB(srb), .DOB(dob[0]), .VLDB(vldb[0]),
        .BUSY(busy[0]));

    ramb_dp_param #(.DW(16), .AW(4), .BW(8), .MODE_A(1), .MODE_B(2), .OREG(1), .CLR_RST(1)) u1 (
        .CLKA(clk), .RSTB(rstb),
        .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .SRA(sra), .DOA(doa[1]), .VLDA(vlda[1]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .SRB(srb), .DOB(dob[1]), .VLDB(vldb[1]),
        .BUSY(busy[1]));

    ramb_dp_param #(.DW(16), .AW(4), .BW(8), .MODE_A(2), .MODE_B(0), .OREG(0), .CLR_RST(1)) u2 (
        .CLKA(clk), .RSTB(rstb),
        .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .SRA(sra), .DOA(doa[2]), .VLDA(vlda[2]),
        .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .SRB(srb), .DOB(dob[2]), .VLDB(vldb[2]),
        .BUSY(busy[2]));

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int          m_mode [3][2] = '{'{0, 1}, '{1, 2}, '{2, 0}};
    int          m_oreg [3]    = '{0, 1, 0};
    logic [15:0] m_mem  [16];
    int          clear_left = 0;
    logic [15:0] m_d1   [3][2];
    logic        m_v1   [3][2];
    logic [15:0] m_d2   [3][2];
    logic        m_v2   [3][2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic port_upd(input int i, input int p, input logic en, input logic [1:0] we,
                            input logic sr, input logic [15:0] old, input logic [15:0] di);
        logic [15:0] merged;
        merged = old;
        for (int l = 0; l < 2; l++) if (we[l]) merged[l*8 +: 8] = di[l*8 +: 8];
        if (!en) begin
            m_v1[i][p] = 1'b0;
        end else if (sr) begin
            m_d1[i][p] = 16'h0;
            m_v1[i][p] = 1'b1;
        end else if (we == 2'b00) begin
            m_d1[i][p] = old;
            m_v1[i][p] = 1'b1;
        end else if (m_mode[i][p] == 0) begin
            m_d1[i][p] = merged;
            m_v1[i][p] = 1'b1;
        end else if (m_mode[i][p] == 1) begin
            m_d1[i][p] = old;
            m_v1[i][p] = 1'b1;
        end else begin
            m_v1[i][p] = 1'b0;
        end
    endtask

    // Predict the effect of the coming edge, clock it, then compare.
    task automatic step();
        logic [15:0] olda, oldb;
        if (rstb) begin
            for (int i = 0; i < 3; i++)
                for (int p = 0; p < 2; p++) begin
                    m_d1[i][p] = 16'h0; m_v1[i][p] = 1'b0;
                    m_d2[i][p] = 16'h0; m_v2[i][p] = 1'b0;
                end
            clear_left = 16;
        end else begin
            for (int i = 0; i < 3; i++)
                for (int p = 0; p < 2; p++) begin
                    m_d2[i][p] = m_d1[i][p];
                    m_v2[i][p] = m_v1[i][p];
                end
            if (clear_left > 0) begin
                for (int i = 0; i < 3; i++)
                    for (int p = 0; p < 2; p++) m_v1[i][p] = 1'b0;
                m_mem[16 - clear_left] = 16'h0;
                clear_left--;
            end else begin
                olda = m_mem[addra];
                oldb = m_mem[addrb];
                for (int i = 0; i < 3; i++) begin
                    port_upd(i, 0, ena, wea, sra, olda, dia);
                    port_upd(i, 1, enb, web, srb, oldb, dib);
                end
                for (int l = 0; l < 2; l++) if (enb && web[l]) m_mem[addrb][l*8 +: 8] = dib[l*8 +: 8];
                for (int l = 0; l < 2; l++) if (ena && wea[l]) m_mem[addra][l*8 +: 8] = dia[l*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.DOA", i),  doa[i],  m_oreg[i] != 0 ? m_d2[i][0] : m_d1[i][0]);
            chk($sformatf("u%0d.VLDA", i), vlda[i], m_oreg[i] != 0 ? m_v2[i][0] : m_v1[i][0]);
            chk($sformatf("u%0d.DOB", i),  dob[i],  m_oreg[i] != 0 ? m_d2[i][1] : m_d1[i][1]);
            chk($sformatf("u%0d.VLDB", i), vldb[i], m_oreg[i] != 0 ? m_v2[i][1] : m_v1[i][1]);
            chk($sformatf("u%0d.BUSY", i), busy[i], clear_left > 0);
        end
    endtask

    task automatic idle();
        ena = 0; enb = 0; sra = 0; srb = 0; wea = 0; web = 0;
    endtask

    int busy_cnt;

    initial begin
        for (int a = 0; a < 16; a++) m_mem[a] = 16'h0;
        rstb = 1; idle(); addra = 0; addrb = 0; dia = 0; dib = 0;
        @(negedge clk);

        // ---- reset and clear sweep, port A reading throughout ----
        step();
        rstb = 0; ena = 1;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy[0]) break;
            busy_cnt++;
            addra = 4'(k);
            step();
        end
        chk("busy_len", busy_cnt, 16);
        for (int a = 0; a < 16; a++) begin
            addra = 4'(a);
            step();
            chk("clr_rd", doa[0], 16'h0000);
        end

        // ---- byte lanes ----
        idle(); ena = 1; wea = 2'b11; addra = 3; dia = 16'hAABB; step();
        wea = 2'b01; dia = 16'h11CC; step();
        idle(); enb = 1; addrb = 3; step();
        chk("lane_rdB", dob[0], 16'hAACC);

        // ---- read-during-write modes on port A ----
        idle(); ena = 1; wea = 2'b11; addra = 5; dia = 16'h1234; step();
        wea = 2'b00; step();
        wea = 2'b11; dia = 16'h5678; step();
        chk("mode_wf", doa[0], 16'h5678);
        chk("mode_nc_do", doa[2], 16'h1234);
        chk("mode_nc_vld", vlda[2], 1'b0);
        idle(); step();
        chk("mode_rf", doa[1], 16'h1234);

        // ---- cross-port collisions ----
        idle(); ena = 1; wea = 2'b10; addra = 7; dia = 16'hAAAA;
        enb = 1; web = 2'b11; addrb = 7; dib = 16'hBBBB; step();
        idle(); enb = 1; addrb = 7; step();
        chk("coll_ww", dob[0], 16'hAABB);
        idle(); ena = 1; wea = 2'b11; addra = 9; dia = 16'h1357; step();
        wea = 2'b00; enb = 1; web = 2'b11; addrb = 9; dib = 16'h0F0F; step();
        chk("coll_rw_u0", doa[0], 16'h1357);
        chk("coll_rw_u2", doa[2], 16'h1357);

        // ---- output register latency and sync clear ----
        idle(); ena = 1; wea = 2'b11; addra = 2; dia = 16'hBEEF; step();
        idle(); step();
        ena = 1; addra = 2; step();
        chk("oreg_e1_vld", vlda[1], 1'b0);
        chk("oreg_e1_do", doa[1], 16'h0000);
        idle(); step();
        chk("oreg_e2_do", doa[1], 16'hBEEF);
        chk("oreg_e2_vld", vlda[1], 1'b1);
        ena = 1; sra = 1; step();
        idle(); step();
        chk("oreg_sr", doa[1], 16'h0000);

        // ---- reset in the middle of a sweep; writes during sweep ignored ----
        rstb = 1; step();
        rstb = 0; ena = 1; wea = 2'b11; dia = 16'hFFFF; enb = 1; web = 2'b11; dib = 16'hEEEE;
        for (int k = 0; k < 7; k++) begin
            addra = 4'(k); addrb = 4'(15 - k); step();
        end
        rstb = 1; step();
        rstb = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy[0]) break;
            busy_cnt++;
            addra = 4'(k); addrb = 4'(k + 3);
            step();
        end
        chk("busy_len_rst", busy_cnt, 16);
        idle(); ena = 1; enb = 1;
        for (int a = 0; a < 16; a++) begin
            addra = 4'(a); addrb = 4'(15 - a);
            step();
            chk("clr2_rdA", doa[0], 16'h0000);
            chk("clr2_rdB", dob[2], 16'h0000);
        end

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 2500; k++) begin
            rstb  = ($urandom_range(0, 499) == 0);
            ena   = ($urandom_range(0, 3) != 0);
            enb   = ($urandom_range(0, 3) != 0);
            wea   = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
            web   = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
            addra = 4'($urandom);
            addrb = ($urandom_range(0, 2) == 0) ? addra : 4'($urandom);
            dia   = 16'($urandom);
            dib   = 16'($urandom);
            sra   = ($urandom_range(0, 9) == 0);
            srb   = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
